fp_addsub_controller: RTL

- Sequential control unit for the single-precision add/sub datapath.
- Captures an operation request and drives the datapath's mux and shift selects: smaller-exponent select, alignment shift amount, normalization source and shift direction.
- Walks the align, normalize and renormalize-after-rounding sequence, and registers the final packed result with a done pulse.
- Sits between the RISC-V FP issue logic (upstream) and the combinational FP datapath (downstream); consumes the datapath's expDiff, fracResult, carry and result.

---
 rtl/fp_addsub_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_controller.sv
// rtl/fp_addsub_controller.sv - sequencing and select control for the single-precision add/sub datapath
module fp_addsub_controller #(
    parameter int MAX_NORM_ITER = 27,
    parameter int SHIFT_SAT     = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_in,
    input  logic [7:0]  expDiff,
    input  logic [26:0] fracResult,
    input  logic        carry,
    input  logic [31:0] result_in,
    output logic        smallerExpSrc,
    output logic [7:0]  shiftRightQtt,
    output logic [1:0]  operation,
    output logic        normalization_src,
    output logic        shift_src,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        zero,
    output logic [31:0] result_out
);
    localparam int CW = $clog2(MAX_NORM_ITER + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NORM_ITER);
    localparam logic [8:0]    SAT9    = 9'(SHIFT_SAT);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_NORM, S_RENORM, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic        small_q, small_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  op_q, op_d;
    logic        nsrc_q, nsrc_d;
    logic        ssrc_q, ssrc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        zero_q, zero_d;
    logic [31:0] res_q, res_d;

    // Magnitude is formed in 9 bits so that -(-128) does not wrap before saturation.
    logic [8:0]    exp_mag;
    logic [7:0]    exp_sat;
    logic [CW-1:0] count_inc;

    assign exp_mag   = expDiff[7] ? (9'd0 - {1'b1, expDiff}) : {1'b0, expDiff};
    assign exp_sat   = (exp_mag > SAT9) ? SAT9[7:0] : exp_mag[7:0];
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        small_d = small_q;
        shift_d = shift_q;
        op_d    = op_q;
        nsrc_d  = nsrc_q;
        ssrc_d  = ssrc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        zero_d  = zero_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    zero_d = 1'b0;
                    if (!op_in[1]) begin
                        op_d    = op_in;
                        err_d   = 1'b0;
                        state_d = S_ALIGN;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ALIGN: begin
                small_d = ~expDiff[7];
                shift_d = exp_sat;
                nsrc_d  = 1'b1;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (!carry && fracResult == 27'd0) begin
                    zero_d  = 1'b1;
                    res_d   = 32'd0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ssrc_d  = carry;
                    nsrc_d  = 1'b0;
                    count_d = '0;
                    state_d = S_RENORM;
                end
            end
            S_RENORM: begin
                if (fracResult[26]) begin
                    res_d   = result_in;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (fracResult == 27'd0) begin
                    zero_d  = 1'b1;
                    res_d   = 32'd0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ssrc_d  = 1'b0;
                    count_d = count_inc;
                    if (count_inc == MAX_CNT) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            small_q <= 1'b1;
            shift_q <= 8'd0;
            op_q    <= 2'b00;
            nsrc_q  <= 1'b1;
            ssrc_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            small_q <= small_d;
            shift_q <= shift_d;
            op_q    <= op_d;
            nsrc_q  <= nsrc_d;
            ssrc_q  <= ssrc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
        end
    end

    assign smallerExpSrc     = small_q;
    assign shiftRightQtt     = shift_q;
    assign operation         = op_q;
    assign normalization_src = nsrc_q;
    assign shift_src         = ssrc_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign zero              = zero_q;
    assign result_out        = res_q;
endmodule
